vc_dest_arbiter: RTL
====================

Name: vc_dest_arbiter

Overview:
- Moves words from the four virtual-channel FIFOs into the two destination FIFOs.
- Selects one non-empty VC per cycle using burst-limited round-robin.
- Routes the popped word to D0 or D1 according to a routing bit in the word.
- Honours the destination almost-full flags and is enabled by the top-level control FSM while it is in the active state.

Parameters:
- DATA_SIZE, 6, width of one FIFO word.
- DEST_BIT, 5, bit index of the word that selects the destination (0 = D0, 1 = D1).
- MAX_BURST, 4, maximum consecutive grants to one VC before the pointer must advance (range 1..15).

Ports:
- clk  input  1  system clock; all registers on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  arbitration permitted; driven by the control FSM in its active state.
- vc_empty  input  4  empty flag of each VC FIFO.
- vc_head  input  4*DATA_SIZE  head word of each first-word-fall-through VC FIFO; VC i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- df_almost_full  input  2  almost-full flag of the D0 and D1 FIFOs.
- vc_pop  output  4  one-hot pop strobe; combinational from inputs and registered state.
- d_push  output  2  one-hot push strobe to D0/D1; registered.
- d_data  output  DATA_SIZE  word pushed; registered.
- arb_idle  output  1  registered; state is IDLE.
- arb_stall  output  1  registered; state is STALL.

Behaviour:
- Eligibility: eligible[i] = !vc_empty[i] && !df_almost_full[vc_head_i[DEST_BIT]].
- Grant: at most one VC per cycle. vc_pop[sel] = enable && any(eligible).
- Selection rule:
  - If eligible[last] and burst_cnt < MAX_BURST, sel = last.
  - Otherwise sel = the first eligible VC scanning last+1, last+2, ... modulo 4, wrapping.
  - If only last is eligible and its burst is exhausted, the scan wraps back to last and it is granted.
  - On a grant to the same VC as last, burst_cnt increments; on a grant to a different VC, burst_cnt = 1 and last = sel. When that wrap-around regrant occurs, burst_cnt = 1 (a new burst).
  - No grant leaves last and burst_cnt unchanged.
- Datapath: latency of 1 cycle from vc_pop to d_push.
  - On a grant in cycle N, in cycle N+1: d_data = vc_head_sel as sampled in N, and d_push[vc_head_sel[DEST_BIT]] = 1, other push bit 0.
  - Without a grant, d_push = 0 and d_data holds its value.
- State register, 2 bits (IDLE, GRANT, STALL), updated every cycle:
  - next = IDLE if !enable or all vc_empty.
  - next = GRANT if a grant is issued this cycle.
  - next = STALL otherwise (requests pending, all blocked by almost-full).
- Flag outputs: arb_idle = (state == IDLE), arb_stall = (state == STALL). Both lag the decision by 1 cycle.
- enable deasserted: vc_pop = 0 in that same cycle. A push already registered still completes in the next cycle. Pointer and burst are retained.
- Almost-full: sampled the same cycle as the grant. The almost-full threshold must leave ≥1 free entry for the in-flight push; the arbiter performs no further accounting.
- Simultaneous events:
  - Both destinations almost-full while VCs are non-empty → STALL, no pops.
  - Almost-full dropping re-enables eligibility in the same cycle.
- Reset (asynchronous, any time, including mid-burst):
  - vc_pop = 0 combinationally.
  - d_push = 0, d_data = 0, state = IDLE, so arb_idle = 1 and arb_stall = 0.
  - last = 3, so the first grant after reset goes to VC0; burst_cnt = 0.
  - A word popped in the cycle reset asserts is dropped.

Optional Feature:
- Macro VC_ARB_STATS_EN.
- Defined:
  - Adds outputs push_cnt0 and push_cnt1, each 16 bits and registered.
  - Each counts d_push on its destination and wraps 16'hFFFF→0.
  - Cleared by reset and also by enable rising edge (edge detector register).
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with all VCs non-empty, release at cycle 0, enable=1, no almost-full, heads route D0 → vc_pop=0001 for 4 cycles (MAX_BURST=4), then 0010. d_push=01 one cycle after each pop, with d_data equal to the head words.
- Only VC2 non-empty, head bit5=1, 6 pops → vc_pop=0100 every cycle. Burst restarts after 4 (wrap-around regrant). d_push=10 in each following cycle.
- VC0 routes D1 and VC1 routes D0; df_almost_full=10 → VC0 skipped, VC1 granted; arb_stall=0. Set df_almost_full=11 → vc_pop=0000 and arb_stall=1 the next cycle.
- enable dropped in the cycle after a grant → the pending d_push still appears once, then d_push=0 and arb_idle=1. Re-enable → arbitration resumes at the same VC with the remaining burst.
- Reset asserted mid-burst at a non-clock time → vc_pop and d_push go to 0 immediately. After release the first grant is to VC0.
- VC_ARB_STATS_EN defined: 20 pushes to D0 and 3 to D1 → push_cnt0=20, push_cnt1=3. Toggle enable 0→1 → both counters clear to 0.

Source files
------------

// File: rtl/vc_dest_arbiter.sv
// Burst-limited round-robin arbiter moving words from four VC FIFOs into two destination FIFOs.
// Optional per-destination push counters are enabled by defining VC_ARB_STATS_EN.
module vc_dest_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int DEST_BIT  = 5,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [3:0]               vc_empty,
  input  logic [4*DATA_SIZE-1:0]   vc_head,
  input  logic [1:0]               df_almost_full,
  output logic [3:0]               vc_pop,
  output logic [1:0]               d_push,
  output logic [DATA_SIZE-1:0]     d_data,
  output logic                     arb_idle,
  output logic                     arb_stall
`ifdef VC_ARB_STATS_EN
  ,
  output logic [15:0]              push_cnt0,
  output logic [15:0]              push_cnt1
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  logic [DATA_SIZE-1:0] head_arr [4];
  logic [3:0]           dest_bit;
  logic [3:0]           eligible;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_vc
      assign head_arr[gi] = vc_head[gi*DATA_SIZE +: DATA_SIZE];
      assign dest_bit[gi] = vc_head[gi*DATA_SIZE + DEST_BIT];
      assign eligible[gi] = !vc_empty[gi] && !df_almost_full[dest_bit[gi]];
    end
  endgenerate

  state_t               state_q, state_d;
  logic [1:0]           last_q, last_d;
  logic [3:0]           burst_q, burst_d;
  logic [1:0]           d_push_q;
  logic [DATA_SIZE-1:0] d_data_q;

  logic       grant;
  logic       keep;
  logic       found;
  logic [1:0] sel;
  logic [1:0] idx;

  // burst_q == 0 only after reset and means "no burst in progress", so the
  // reset value of last (3) is not continued and the scan starts at VC0.
  always_comb begin
    keep  = eligible[last_q] && (burst_q != 4'd0) && (burst_q < 4'(MAX_BURST));
    sel   = last_q;
    found = 1'b0;
    idx   = last_q;
    if (!keep) begin
      for (int k = 1; k <= 4; k++) begin
        idx = last_q + 2'(k);
        if (!found && eligible[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end

    grant = !reset && enable && (|eligible);

    last_d  = last_q;
    burst_d = burst_q;
    if (grant) begin
      last_d  = sel;
      burst_d = keep ? (burst_q + 4'd1) : 4'd1;
    end

    if (!enable || (&vc_empty)) begin
      state_d = ST_IDLE;
    end else if (grant) begin
      state_d = ST_GRANT;
    end else begin
      state_d = ST_STALL;
    end
  end

  assign vc_pop = grant ? (4'b0001 << sel) : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_q   <= 2'd3;
      burst_q  <= 4'd0;
      d_push_q <= 2'b00;
      d_data_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      if (grant) begin
        d_push_q <= dest_bit[sel] ? 2'b10 : 2'b01;
        d_data_q <= head_arr[sel];
      end else begin
        d_push_q <= 2'b00;
      end
    end
  end

  assign d_push    = d_push_q;
  assign d_data    = d_data_q;
  assign arb_idle  = (state_q == ST_IDLE);
  assign arb_stall = (state_q == ST_STALL);

`ifdef VC_ARB_STATS_EN
  logic        enable_q;
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  // A rising edge of enable starts a fresh measurement window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b0;
      cnt0_q   <= 16'd0;
      cnt1_q   <= 16'd0;
    end else begin
      enable_q <= enable;
      if (enable && !enable_q) begin
        cnt0_q <= 16'd0;
        cnt1_q <= 16'd0;
      end else begin
        if (d_push_q[0]) cnt0_q <= cnt0_q + 16'd1;
        if (d_push_q[1]) cnt1_q <= cnt1_q + 16'd1;
      end
    end
  end

  assign push_cnt0 = cnt0_q;
  assign push_cnt1 = cnt1_q;
`endif

endmodule
